// File: rtl/pipe_control.sv
// pipe_control
//   Hazard controller and run-state sequencer for the five-stage Y86 pipeline.
//   It decodes the F/D/E/M/W stage fields each cycle and drives the stall and
//   bubble controls of the pipeline registers. These cover the load/use
//   interlock, the mispredicted-jump squash, the ret fetch hold and the
//   exception drain. A RUN/DRAIN/HALTED sequencer freezes the pipeline once a
//   non-AOK status retires. Wrap-around counters track cycles, retired
//   instructions and each hazard class.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   D_icode                  icode in the decode register
//   d_srcA, d_srcB           decode source register IDs (F = none)
//   E_icode, E_dstM          execute-stage icode and memory destination
//   e_Cnd                    execute branch condition
//   M_icode                  memory-stage icode
//   m_stat, W_stat           memory-output and writeback status
//   W_icode                  writeback icode
//   cnt_clr                  synchronous clear of all counters
//   F_stall .. W_stall       pipeline register controls (combinational)
//   state, halted            sequencer state (RUN=0, DRAIN=1, HALTED=2)
//   cyc_cnt .. rs_cnt        cycle, retired, load/use, mispredict, ret-stall counts
module pipe_control #(
   parameter int CW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    D_icode,
   input  logic [3:0]    d_srcA,
   input  logic [3:0]    d_srcB,
   input  logic [3:0]    E_icode,
   input  logic [3:0]    E_dstM,
   input  logic          e_Cnd,
   input  logic [3:0]    M_icode,
   input  logic [3:0]    m_stat,
   input  logic [3:0]    W_stat,
   input  logic [3:0]    W_icode,
   input  logic          cnt_clr,
   output logic          F_stall,
   output logic          D_stall,
   output logic          D_bubble,
   output logic          E_bubble,
   output logic          M_bubble,
   output logic          W_stall,
   output logic [1:0]    state,
   output logic          halted,
   output logic [CW-1:0] cyc_cnt,
   output logic [CW-1:0] ret_cnt,
   output logic [CW-1:0] lu_cnt,
   output logic [CW-1:0] mp_cnt,
   output logic [CW-1:0] rs_cnt
);

   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] S_AOK = 4'h1;
   localparam logic [3:0] S_HLT = 4'h2;
   localparam logic [3:0] S_ADR = 4'h3;
   localparam logic [3:0] S_INS = 4'h4;

   localparam logic [3:0] RNONE = 4'hF;

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   function automatic logic is_exc(input logic [3:0] stat);
      return (stat == S_ADR) || (stat == S_INS) || (stat == S_HLT);
   endfunction

   // Counters wrap naturally at 2^CW.
   function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cur, input logic inc);
      return inc ? cur + {{(CW-1){1'b0}}, 1'b1} : cur;
   endfunction

   logic lu, mp, rh, exc_m, exc_w, run_en, retire;

   // Hazard decode
   always_comb begin
      lu     = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
               (E_dstM != RNONE) &&
               ((E_dstM == d_srcA) || (E_dstM == d_srcB));
      mp     = (E_icode == I_JXX) && !e_Cnd;
      rh     = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
      exc_m  = is_exc(m_stat);
      exc_w  = is_exc(W_stat);
      run_en = (state != ST_HALTED);
      retire = (W_stat == S_AOK) && (W_icode != I_NOP);
   end

   // Control outputs: reset flushes with bubbles, HALTED freezes everything,
   // otherwise hazards drive them. Stall beats bubble in decode so a ret held
   // behind a load/use does not squash the stalled instruction.
   always_comb begin
      F_stall  = lu || rh;
      D_stall  = lu;
      D_bubble = mp || (rh && !lu);
      E_bubble = mp || lu;
      M_bubble = exc_m || exc_w;
      W_stall  = exc_w;
      if (rst) begin
         F_stall  = 1'b0;
         D_stall  = 1'b0;
         D_bubble = 1'b1;
         E_bubble = 1'b1;
         M_bubble = 1'b1;
         W_stall  = 1'b0;
      end else if (state == ST_HALTED) begin
         F_stall  = 1'b1;
         D_stall  = 1'b1;
         D_bubble = 1'b0;
         E_bubble = 1'b1;
         M_bubble = 1'b1;
         W_stall  = 1'b1;
      end
   end

   assign halted = (state == ST_HALTED);

   // Run-state sequencer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         case (state)
            ST_RUN: begin
               if (exc_w)      state <= ST_HALTED;
               else if (exc_m) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (exc_w) state <= ST_HALTED;
            end
            ST_HALTED: state <= ST_HALTED;
            default:   state <= ST_RUN;
         endcase
      end
   end

   // Performance counters: clear wins over any increment, even in HALTED.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_cnt <= '0;
         ret_cnt <= '0;
         lu_cnt  <= '0;
         mp_cnt  <= '0;
         rs_cnt  <= '0;
      end else if (cnt_clr) begin
         cyc_cnt <= '0;
         ret_cnt <= '0;
         lu_cnt  <= '0;
         mp_cnt  <= '0;
         rs_cnt  <= '0;
      end else begin
         cyc_cnt <= cnt_next(cyc_cnt, run_en);
         ret_cnt <= cnt_next(ret_cnt, run_en && retire);
         lu_cnt  <= cnt_next(lu_cnt,  run_en && lu);
         mp_cnt  <= cnt_next(mp_cnt,  run_en && mp);
         rs_cnt  <= cnt_next(rs_cnt,  run_en && rh && !lu);
      end
   end

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control with 4-bit counters so wrap is reachable.
module tb_pipe_control;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst;
   logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat, W_icode;
   logic e_Cnd, cnt_clr;
   logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
   logic [1:0] state;
   logic [CW-1:0] cyc_cnt, ret_cnt, lu_cnt, mp_cnt, rs_cnt;
   logic [5:0] ctl;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   pipe_control #(.CW(CW)) dut (
      .clk(clk), .rst(rst),
      .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
      .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode),
      .cnt_clr(cnt_clr),
      .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
      .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
      .state(state), .halted(halted),
      .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .lu_cnt(lu_cnt),
      .mp_cnt(mp_cnt), .rs_cnt(rs_cnt)
   );

   assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
      E_icode = 4'h1; E_dstM = 4'hF; e_Cnd = 1'b0;
      M_icode = 4'h1; m_stat = 4'h1; W_stat = 4'h1; W_icode = 4'h1;
      cnt_clr = 1'b0;
   endtask

   task automatic set_lu();
      E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
   endtask

   task automatic clr();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      #1;
      chk("rst_ctl", ctl, 6'b001110);
      chk("rst_state", state, 2'd0);
      chk("rst_cyc", cyc_cnt, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("idle_ctl", ctl, 6'b000000);

      // load/use
      clr();
      chk("clr_cyc", cyc_cnt, 0);
      set_lu();
      #1;
      chk("lu_ctl", ctl, 6'b110100);
      tick();
      chk("lu_cnt", lu_cnt, 1);
      chk("lu_cyc", cyc_cnt, 1);
      idle();

      // mispredict, then taken jump
      E_icode = 4'h7; e_Cnd = 1'b0;
      #1;
      chk("mp_ctl", ctl, 6'b001100);
      tick();
      chk("mp_cnt", mp_cnt, 1);
      e_Cnd = 1'b1;
      #1;
      chk("jtaken_ctl", ctl, 6'b000000);
      tick();
      chk("jtaken_mp_cnt", mp_cnt, 1);
      idle();

      // retirement counting: NOP does not count, other AOK icode does
      clr();
      tick();
      chk("ret_nop", ret_cnt, 0);
      W_icode = 4'h6;
      tick();
      chk("ret_cnt", ret_cnt, 1);
      idle();

      // ret hold for three cycles
      clr();
      D_icode = 4'h9;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("ret_ctl", ctl, 6'b101000);
         tick();
      end
      chk("rs_cnt3", rs_cnt, 3);
      set_lu();
      #1;
      chk("ret_lu_ctl", ctl, 6'b110100);
      tick();
      chk("ret_lu_rs", rs_cnt, 3);
      chk("ret_lu_lu", lu_cnt, 1);
      idle();
      D_icode = 4'h9; E_icode = 4'h7; e_Cnd = 1'b0;
      #1;
      chk("ret_mp_ctl", ctl, 6'b101100);
      idle();

      // cycle counter wrap
      clr();
      repeat (15) tick();
      chk("cyc_15", cyc_cnt, 15);
      tick();
      chk("cyc_wrap", cyc_cnt, 0);

      // clear beats a load/use increment
      tick();
      set_lu();
      cnt_clr = 1'b1;
      tick();
      chk("clr_lu", lu_cnt, 0);
      chk("clr_lu_cyc", cyc_cnt, 0);
      idle();

      // exception drain
      m_stat = 4'h3;
      #1;
      chk("excm_ctl", ctl, 6'b000010);
      tick();
      chk("drain_state", state, 2'd1);
      m_stat = 4'h1; W_stat = 4'h3;
      #1;
      chk("excw_ctl", ctl, 6'b000011);
      chk("excw_halted", halted, 1'b0);
      tick();
      chk("halted", halted, 1'b1);
      chk("halt_state", state, 2'd2);
      chk("halt_cyc", cyc_cnt, 2);
      W_stat = 4'h1;
      set_lu();
      #1;
      chk("halt_ctl", ctl, 6'b110111);
      repeat (10) tick();
      chk("halt_cyc_frozen", cyc_cnt, 2);
      chk("halt_lu_frozen", lu_cnt, 0);
      chk("halt_stays", state, 2'd2);
      idle();

      // async reset out of HALTED, before any clock edge
      rst = 1'b1;
      #1;
      chk("arst_state", state, 2'd0);
      chk("arst_cyc", cyc_cnt, 0);
      chk("arst_ctl", ctl, 6'b001110);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("arst_run", state, 2'd0);

      // clear works in HALTED
      W_stat = 4'h4;
      tick();
      chk("halt2", halted, 1'b1);
      chk("halt2_cyc", cyc_cnt, 1);
      W_stat = 4'h1;
      clr();
      chk("halt_clr_cyc", cyc_cnt, 0);
      chk("halt_clr_state", state, 2'd2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/pipe_control.md
# pipe_control

Hazard controller and run-state sequencer for the five-stage Y86 pipeline. Each cycle it decodes the F/D/E/M/W stage fields and drives the stall and bubble controls of the pipeline registers: load/use interlock, mispredicted-jump squash, `ret` fetch hold and exception drain. A three-state run FSM freezes the whole pipeline once a non-AOK status retires. Wrap-around performance counters track cycles, retired instructions and each hazard class.

## Interface
- `CW`, 32, width of every performance counter
- `clk`  in  1  pipeline clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `D_icode`  in  4  icode in decode register
- `d_srcA`, `d_srcB`  in  4 each  decode source register IDs (F = none)
- `E_icode`, `E_dstM`  in  4 each  execute-stage icode and memory destination
- `e_Cnd`  in  1  execute branch condition
- `M_icode`  in  4  memory-stage icode
- `m_stat`, `W_stat`  in  4 each  memory-output and writeback status
- `W_icode`  in  4  writeback icode
- `cnt_clr`  in  1  synchronous clear of all counters
- `F_stall`, `D_stall`, `D_bubble`, `E_bubble`, `M_bubble`, `W_stall`  out  1 each  pipeline register controls
- `state`  out  2  FSM state: RUN=0, DRAIN=1, HALTED=2
- `halted`  out  1  state==HALTED
- `cyc_cnt`, `ret_cnt`, `lu_cnt`, `mp_cnt`, `rs_cnt`  out  CW each  cycles, retired, load/use, mispredict and ret-stall counts

## Operation
- Encodings: icode HALT=0, NOP=1, MRMOVQ=5, JXX=7, RET=9, POPQ=B. stat AOK=1, HLT=2, ADR=3, INS=4. RNONE=F.
- `lu` = E_icode∈{MRMOVQ,POPQ} ∧ E_dstM≠F ∧ E_dstM∈{d_srcA,d_srcB}
- `mp` = E_icode==JXX ∧ !e_Cnd
- `rh` = RET∈{D_icode,E_icode,M_icode}
- `exc_m` = m_stat∈{ADR,INS,HLT}. `exc_w` = W_stat∈{ADR,INS,HLT}
- Controls in RUN and DRAIN (combinational from inputs):
  - F_stall = lu ∨ rh
  - D_stall = lu
  - D_bubble = mp ∨ (rh ∧ !lu). Stall has priority, so D_stall and D_bubble are never both 1.
  - E_bubble = mp ∨ lu
  - M_bubble = exc_m ∨ exc_w
  - W_stall = exc_w
- In HALTED all of F_stall, D_stall, E_bubble, M_bubble and W_stall are 1; D_bubble is 0.
- While rst is high: F_stall=0, D_stall=0, D_bubble=E_bubble=M_bubble=1, W_stall=0. This flushes the pipeline with NOPs.
- FSM transitions:
  - RUN→DRAIN when exc_m ∧ !exc_w
  - RUN→HALTED or DRAIN→HALTED when exc_w
  - DRAIN stays in DRAIN otherwise
  - HALTED is exited only by rst
- Counters are registered and advance only in RUN or DRAIN; all are frozen in HALTED.
  - cyc_cnt +1 every cycle
  - ret_cnt +1 when W_stat==AOK ∧ W_icode≠NOP
  - lu_cnt +1 when lu
  - mp_cnt +1 when mp
  - rs_cnt +1 when rh ∧ !lu
- Counters wrap modulo 2^CW.
- cnt_clr zeroes all counters on the next edge. It overrides any increment in that cycle and works in any state, including HALTED.

## Timing
- Reset (async): state=RUN, all counters 0.
- Control outputs have zero latency (same cycle as inputs); they are sampled by the pipeline registers at the next rising clk.
- `state`, `halted` and counters update at the rising edge after the qualifying input condition.
- The cycle exc_w is first seen: W_stall=1 and M_bubble=1 immediately from the combinational path. halted=1 from the following cycle.
- rst asserted mid-operation returns to RUN with counters at 0 immediately, with no wait for the clock.
- Simultaneous lu ∧ rh: F_stall=1, D_stall=1, D_bubble=0, E_bubble=1.
- Simultaneous mp ∧ rh: D_bubble=1, E_bubble=1, F_stall=1.
- Counter at 2^CW−1 with an increment goes to 0.

## Test plan
- Load/use: E_icode=MRMOVQ, E_dstM=3, d_srcA=3 → F_stall=D_stall=E_bubble=1, D_bubble=0; lu_cnt 0→1 after one edge.
- Mispredict: E_icode=7, e_Cnd=0 → D_bubble=E_bubble=1, F_stall=0; mp_cnt +1. With e_Cnd=1 → all controls 0.
- Ret: D_icode=9 for 3 cycles, no lu → F_stall=D_bubble=1 each cycle; rs_cnt=3. Combined with lu → D_stall=1, D_bubble=0, rs_cnt unchanged.
- Exception drain: m_stat=ADR → M_bubble=1, state=DRAIN next cycle. Then W_stat=ADR → W_stall=1, halted=1 next cycle; all stalls held; cyc_cnt frozen for 10 cycles.
- Reset and counters: async rst mid-HALTED → state=RUN, counters 0 before the next clk. With CW=4, 16 RUN cycles → cyc_cnt wraps to 0. cnt_clr together with lu → lu_cnt=0.
